// File: rtl/keccak_arbiter_if.sv
// keccak_arbiter_if: requester, keccak core and digest signals of keccak_arbiter
interface keccak_arbiter_if;
    logic         req0_valid, req1_valid;
    logic [31:0]  req0_data, req1_data;
    logic         req0_last, req1_last;
    logic [1:0]   req0_byte_num, req1_byte_num;
    logic         req0_ready, req1_ready;
    logic         core_reset;
    logic [31:0]  core_in;
    logic         core_in_ready, core_is_last;
    logic [1:0]   core_byte_num;
    logic         core_buffer_full;
    logic [511:0] core_out;
    logic         core_out_ready;
    logic         dig_valid, dig_id, dig_err, dig_ack;
    logic [511:0] dig_data;
    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data, req0_last, req1_last,
               req0_byte_num, req1_byte_num, core_buffer_full, core_out, core_out_ready, dig_ack,
        output req0_ready, req1_ready, core_reset, core_in, core_in_ready, core_is_last,
               core_byte_num, dig_valid, dig_id, dig_data, dig_err
    );
    modport master (
        output req0_valid, req1_valid, req0_data, req1_data, req0_last, req1_last,
               req0_byte_num, req1_byte_num, core_buffer_full, core_out, core_out_ready, dig_ack,
        input  req0_ready, req1_ready, core_reset, core_in, core_in_ready, core_is_last,
               core_byte_num, dig_valid, dig_id, dig_data, dig_err
    );
endinterface

// File: rtl/keccak_arbiter.sv
// keccak_arbiter: round-robin two-requester front end for keccak; WAIT watchdog enabled by KECCAK_ARB_TIMEOUT_EN
module keccak_arbiter #(
    parameter int CLR_CYCLES = 1,
    parameter int TIMEOUT    = 1024
) (
    input logic             clk,
    input logic             reset_n,
    keccak_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT, DONE} state_t;
    localparam int CW = $clog2(CLR_CYCLES + 1);
    state_t        state, state_nx;
    logic [CW-1:0] clr_cnt;
    logic          gnt, ptr, gnt_nx, any_valid, clr_done;
    logic          g_valid, g_last, xfer, capture, timeout;
    logic [31:0]   g_data;
    logic [1:0]    g_bn;
    assign any_valid = bus.req0_valid || bus.req1_valid;
    assign gnt_nx    = bus.req0_valid && bus.req1_valid ? !ptr : bus.req1_valid;
    assign clr_done  = clr_cnt == CW'(CLR_CYCLES - 1);
    assign g_valid   = gnt ? bus.req1_valid : bus.req0_valid;
    assign g_last    = gnt ? bus.req1_last : bus.req0_last;
    assign g_data    = gnt ? bus.req1_data : bus.req0_data;
    assign g_bn      = gnt ? bus.req1_byte_num : bus.req0_byte_num;
    assign xfer      = state == STREAM && g_valid && !bus.core_buffer_full;
    assign capture   = state == WAIT && (bus.core_out_ready || timeout);
`ifdef KECCAK_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) wait_cnt <= '0;
        else wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
    assign timeout = wait_cnt == TW'(TIMEOUT - 1);
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            gnt          <= 1'b0;
            ptr          <= 1'b1;
            clr_cnt      <= '0;
            bus.dig_data <= '0;
            bus.dig_id   <= 1'b0;
            bus.dig_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : '0;
            if (state == IDLE) gnt <= gnt_nx;
            if (state == DONE && bus.dig_ack) ptr <= gnt;
            // a watchdog expiry hands back an all-zero digest flagged as an error
            if (capture) begin
                bus.dig_data <= bus.core_out_ready ? bus.core_out : '0;
                bus.dig_id   <= gnt;
                bus.dig_err  <= !bus.core_out_ready;
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any_valid ? CLEAR : IDLE;
            CLEAR:   state_nx = clr_done ? STREAM : CLEAR;
            STREAM:  state_nx = xfer && g_last ? WAIT : STREAM;
            WAIT:    state_nx = capture ? DONE : WAIT;
            DONE:    state_nx = bus.dig_ack ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus.core_reset    = state == CLEAR;
        bus.core_in       = state == STREAM ? g_data : '0;
        bus.core_in_ready = xfer;
        bus.core_is_last  = xfer && g_last;
        bus.core_byte_num = xfer ? g_bn : 2'b00;
        bus.req0_ready    = state == STREAM && !gnt && !bus.core_buffer_full;
        bus.req1_ready    = state == STREAM && gnt && !bus.core_buffer_full;
        bus.dig_valid     = state == DONE;
    end
endmodule

// File: tb/tb_keccak_arbiter.sv
// tb_keccak_arbiter: random two-requester traffic checked against a message-level reference model
module tb_keccak_arbiter;
    localparam int CLR = 1, TMO = 16, NMSG = 40;
    localparam int P_IDLE = 0, P_CLR = 1, P_STR = 2, P_WAIT = 3, P_DONE = 4;
`ifdef KECCAK_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    typedef logic [34:0] word_t;
    logic clk = 1'b0, reset_n = 1'b0;
    int checks = 0, failures = 0;
    word_t rq[2][$];
    logic v[2];
    logic full, oready, ack, gnt, ptr, exp_err, rst_done;
    logic [511:0] cout, exp_dig;
    int ph, clr, wcnt, gen, done;
    keccak_arbiter_if bus();
    keccak_arbiter #(.CLR_CYCLES(CLR), .TIMEOUT(TMO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add_msg(input int r);
        int n;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) rq[r].push_back({$urandom, i == n - 1, 2'($urandom)});
        gen++;
    endtask

    function automatic word_t front(input int r);
        return rq[r].size() > 0 ? rq[r][0] : word_t'({$urandom, 3'($urandom)});
    endfunction

    task automatic drive();
        logic no_out;
        if (gen < NMSG && $urandom_range(7) == 0) add_msg(int'($urandom_range(1)));
        for (int r = 0; r < 2; r++)
            v[r] = rq[r].size() > 0 && ((done == 0 && ph == P_IDLE) || $urandom_range(4) != 0);
        bus.req0_valid = v[0];
        bus.req1_valid = v[1];
        {bus.req0_data, bus.req0_last, bus.req0_byte_num} = front(0);
        {bus.req1_data, bus.req1_last, bus.req1_byte_num} = front(1);
        full = $urandom_range(3) == 0;
        no_out = TMO_EN && done % 4 == 1;
        oready = !no_out && $urandom_range(5) == 0;
        ack = $urandom_range(2) == 0;
        for (int i = 0; i < 16; i++) cout[32*i +: 32] = $urandom;
        bus.core_buffer_full = full;
        bus.core_out_ready = oready;
        bus.core_out = cout;
        bus.dig_ack = ack;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 512'({bus.req1_ready, bus.req0_ready, bus.core_reset, bus.core_in_ready,
              bus.core_is_last, bus.core_byte_num, bus.dig_valid, bus.dig_id, bus.dig_err}), 512'(0));
        check({tag, "_core_in"}, 512'(bus.core_in), 512'(0));
        check({tag, "_dig_data"}, bus.dig_data, 512'(0));
    endtask

    task automatic step();
        logic xf;
        word_t w;
        w = rq[gnt].size() > 0 ? rq[gnt][0] : '0;
        xf = ph == P_STR && v[gnt] && !full;
        check("core_reset", 512'(bus.core_reset), 512'(ph == P_CLR));
        check("ready", 512'({bus.req1_ready, bus.req0_ready}),
              512'(ph == P_STR && !full ? (gnt ? 2'b10 : 2'b01) : 2'b00));
        check("core_in_ready", 512'(bus.core_in_ready), 512'(xf));
        if (xf) check("core_word", 512'({bus.core_in, bus.core_is_last, bus.core_byte_num}), 512'(w));
        else check("core_idle", 512'({bus.core_is_last, bus.core_byte_num}), 512'(0));
        check("dig_valid", 512'(bus.dig_valid), 512'(ph == P_DONE));
        if (ph == P_DONE) begin
            check("dig_data", bus.dig_data, exp_dig);
            check("dig_id_err", 512'({bus.dig_id, bus.dig_err}), 512'({gnt, exp_err}));
        end
        case (ph)
            P_IDLE: if (v[0] || v[1]) begin
                gnt = v[0] && v[1] ? !ptr : v[1];
                ph = P_CLR;
                clr = 0;
            end
            P_CLR: begin
                clr++;
                if (clr == CLR) ph = P_STR;
            end
            P_STR: if (xf) begin
                void'(rq[gnt].pop_front());
                if (w[2]) begin
                    ph = P_WAIT;
                    wcnt = 0;
                end
            end
            P_WAIT: begin
                wcnt++;
                if (oready) begin
                    ph = P_DONE;
                    exp_dig = cout;
                    exp_err = 1'b0;
                end else if (TMO_EN && wcnt == TMO) begin
                    ph = P_DONE;
                    exp_dig = '0;
                    exp_err = 1'b1;
                end
            end
            P_DONE: if (ack) begin
                ph = P_IDLE;
                ptr = gnt;
                done++;
            end
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic mid_reset();
        word_t w;
        #2 reset_n = 1'b0;
        #1 check_zero("midrst");
        while (rq[gnt].size() > 0) begin
            w = rq[gnt].pop_front();
            if (w[2]) break;
        end
        ph = P_IDLE;
        ptr = 1'b1;
        v[0] = 1'b0;
        v[1] = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        rst_done = 1'b1;
    endtask

    initial begin
        ph = P_IDLE; ptr = 1'b1; gnt = 1'b0; gen = 0; done = 0; rst_done = 1'b0;
        exp_dig = '0; exp_err = 1'b0;
        rq[0].push_back({32'h48656c6c, 1'b0, 2'd0});
        rq[0].push_back({32'h6f2c2077, 1'b0, 2'd0});
        rq[0].push_back({32'h6f726c64, 1'b0, 2'd0});
        rq[0].push_back({32'h21202020, 1'b1, 2'd1});
        rq[1].push_back({32'h646f672e, 1'b0, 2'd0});
        rq[1].push_back({32'h00000000, 1'b1, 2'd0});
        gen = 2;
        add_msg(0);
        drive();
        #1 check_zero("reset");
        v[0] = 1'b0;
        v[1] = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        for (int cyc = 0; cyc < 20000 &&
             !(gen == NMSG && rq[0].size() == 0 && rq[1].size() == 0 && ph == P_IDLE); cyc++) begin
            @(posedge clk);
            #1 drive();
            @(negedge clk);
            if (!rst_done && ph == P_STR && done >= 6) mid_reset();
            else step();
        end
        check("drain", 512'(rq[0].size() + rq[1].size() + (ph == P_IDLE ? 0 : 1)), 512'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
